// File: rtl/aes_input_loader_if.sv
// Plaintext word handshake between the upstream word source and aes_input_loader.
interface aes_input_loader_if;
    logic        word_valid;
    logic [31:0] word_in;
    logic        word_ready;

    modport master (
        output word_valid,
        output word_in,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_in,
        output word_ready
    );
endinterface

// File: rtl/aes_input_loader.sv
// AES-128 front end: gathers four plaintext words, applies the initial AddRoundKey and
// issues paced blocks to round stage 0. Optional blk_count output: AES_LOADER_BLKCNT_EN.
module aes_input_loader #(
    parameter int unsigned ISSUE_GAP = 4
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                key_load,
    input  logic [127:0]        cipher_key,
    aes_input_loader_if.slave   wbus,
    output logic                enable,
    output logic [127:0]        i_text,
    output logic [127:0]        key,
    output logic                busy
`ifdef AES_LOADER_BLKCNT_EN
    ,
    output logic [15:0]         blk_count
`endif
);

    typedef enum logic {
        FILL,
        HOLD
    } state_e;

    localparam logic [7:0] GAP_LOAD = 8'(ISSUE_GAP - 1);

    state_e         state_q, state_d;
    logic [31:0]    wbuf_q [4];
    logic [1:0]     wcnt_q;
    logic [7:0]     gcnt_q;
    logic [127:0]   kreg_q;
    logic [127:0]   i_text_q;
    logic [127:0]   key_q;
    logic           enable_q;
    logic           ready;
    logic           accept;
    logic           last_word;
    logic           issue;
    logic [127:0]   block;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: if (last_word && (gcnt_q != '0)) state_d = HOLD;
            HOLD: if (gcnt_q == '0) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // The 4th word bypasses the buffer so it can be issued on its own accept edge.
    always_comb begin
        ready     = resetn && (state_q == FILL);
        accept    = wbus.word_valid && ready;
        last_word = accept && (wcnt_q == 2'd3);
        issue     = (last_word || (state_q == HOLD)) && (gcnt_q == '0);
        block     = {(last_word ? wbus.word_in : wbuf_q[3]), wbuf_q[2], wbuf_q[1], wbuf_q[0]};
    end

    assign wbus.word_ready = ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 4; i++) begin
                wbuf_q[i] <= '0;
            end
            wcnt_q   <= '0;
            gcnt_q   <= '0;
            kreg_q   <= '0;
            i_text_q <= '0;
            key_q    <= '0;
            enable_q <= 1'b0;
        end else begin
            if (key_load) begin
                kreg_q <= cipher_key;
            end
            if (accept) begin
                wbuf_q[wcnt_q] <= wbus.word_in;
                wcnt_q         <= wcnt_q + 2'd1;
            end
            enable_q <= issue;
            if (issue) begin
                i_text_q <= block ^ kreg_q;
                key_q    <= kreg_q;
                wcnt_q   <= '0;
                gcnt_q   <= GAP_LOAD;
            end else if (gcnt_q != '0) begin
                gcnt_q <= gcnt_q - 8'd1;
            end
        end
    end

`ifdef AES_LOADER_BLKCNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            blk_cnt_q <= '0;
        end else if (issue) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign blk_count = blk_cnt_q;
`endif

    assign enable = enable_q;
    assign i_text = i_text_q;
    assign key    = key_q;
    assign busy   = (wcnt_q != '0) || (state_q == HOLD) || (gcnt_q != '0);

endmodule

// File: tb/tb_aes_input_loader.sv
// Drives two loaders (gap 8 and gap 4) with one stimulus stream and checks both
// against a block-level reference model of the loader.
module tb_aes_input_loader;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           kl = 1'b0;
    logic [127:0]   ck = '0;
    logic           vin = 1'b0;
    logic [31:0]    win = '0;

    logic           en_o  [2];
    logic [127:0]   txt_o [2];
    logic [127:0]   key_o [2];
    logic           busy_o[2];
    logic           rdy   [2];
`ifdef AES_LOADER_BLKCNT_EN
    logic [15:0]    blk_o [2];
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    aes_input_loader_if bus0 ();
    aes_input_loader_if bus1 ();

    assign bus0.word_valid = vin;
    assign bus0.word_in    = win;
    assign bus1.word_valid = vin;
    assign bus1.word_in    = win;
    assign rdy[0]          = bus0.word_ready;
    assign rdy[1]          = bus1.word_ready;

    aes_input_loader #(.ISSUE_GAP(8)) u_dut0 (
        .clock      (clk),
        .resetn     (resetn),
        .key_load   (kl),
        .cipher_key (ck),
        .wbus       (bus0),
        .enable     (en_o[0]),
        .i_text     (txt_o[0]),
        .key        (key_o[0]),
        .busy       (busy_o[0])
`ifdef AES_LOADER_BLKCNT_EN
        ,
        .blk_count  (blk_o[0])
`endif
    );

    aes_input_loader #(.ISSUE_GAP(4)) u_dut1 (
        .clock      (clk),
        .resetn     (resetn),
        .key_load   (kl),
        .cipher_key (ck),
        .wbus       (bus1),
        .enable     (en_o[1]),
        .i_text     (txt_o[1]),
        .key        (key_o[1]),
        .busy       (busy_o[1])
`ifdef AES_LOADER_BLKCNT_EN
        ,
        .blk_count  (blk_o[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: words pending since the last issue and edges elapsed since it.
    int             m_cnt  [2] = '{0, 0};
    logic [31:0]    m_w    [2][4];
    int             m_since[2] = '{1000, 1000};
    logic [127:0]   m_key  [2] = '{'0, '0};
    logic           e_en   [2] = '{1'b0, 1'b0};
    logic [127:0]   e_txt  [2] = '{'0, '0};
    logic [127:0]   e_key  [2] = '{'0, '0};
    logic [15:0]    e_blk  [2] = '{16'd0, 16'd0};

    function automatic int gap_of(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                m_cnt[k]   = 0;
                m_since[k] = 1000;
                m_key[k]   = '0;
                e_en[k]    = 1'b0;
                e_txt[k]   = '0;
                e_key[k]   = '0;
                e_blk[k]   = '0;
            end else begin
                if (m_since[k] < 1000) m_since[k]++;
                if (vin && m_cnt[k] < 4) begin
                    m_w[k][m_cnt[k]] = win;
                    m_cnt[k]++;
                end
                e_en[k] = 1'b0;
                if (m_cnt[k] == 4 && m_since[k] >= gap_of(k)) begin
                    e_en[k]    = 1'b1;
                    e_txt[k]   = {m_w[k][3], m_w[k][2], m_w[k][1], m_w[k][0]} ^ m_key[k];
                    e_key[k]   = m_key[k];
                    m_cnt[k]   = 0;
                    m_since[k] = 0;
                    e_blk[k]   = e_blk[k] + 16'd1;
                end
                if (kl) m_key[k] = ck;
            end
        end
    end

    int cyc = 0;
    int last_en[2] = '{-1, -1};

    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!resetn) begin
                    check_eq($sformatf("rst_en%0d", k),   en_o[k],   '0);
                    check_eq($sformatf("rst_txt%0d", k),  txt_o[k],  '0);
                    check_eq($sformatf("rst_key%0d", k),  key_o[k],  '0);
                    check_eq($sformatf("rst_rdy%0d", k),  rdy[k],    '0);
                    check_eq($sformatf("rst_busy%0d", k), busy_o[k], '0);
                end else begin
                    check_eq($sformatf("en%0d", k),   en_o[k],  e_en[k]);
                    check_eq($sformatf("txt%0d", k),  txt_o[k], e_txt[k]);
                    check_eq($sformatf("key%0d", k),  key_o[k], e_key[k]);
                    check_eq($sformatf("rdy%0d", k),  rdy[k],   (m_cnt[k] < 4));
                    check_eq($sformatf("busy%0d", k), busy_o[k],
                             (m_cnt[k] != 0) || (m_since[k] < gap_of(k) - 1));
`ifdef AES_LOADER_BLKCNT_EN
                    check_eq($sformatf("blk%0d", k), blk_o[k], e_blk[k]);
`endif
                    if (en_o[k]) begin
                        if (last_en[k] >= 0)
                            check_eq($sformatf("spacing%0d", k), (cyc - last_en[k] >= gap_of(k)), 1'b1);
                        last_en[k] = cyc;
                    end
                end
            end
        end
    end

    // Hold the word until the gap-8 loader takes it, so that stream is lossless.
    task automatic send_word(input logic [31:0] w, input logic load, input logic [127:0] nk);
        int t = 0;
        @(negedge clk);
        vin = 1'b1;
        win = w;
        kl  = load;
        ck  = nk;
        #1;
        while (!rdy[0] && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 100) check_eq("ready_timeout", 1'b0, 1'b1);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vin = 1'b0;
            kl  = 1'b0;
        end
    endtask

    task automatic wait_en0();
        int t = 0;
        @(negedge clk);
        vin = 1'b0;
        kl  = 1'b0;
        #1;
        while (!en_o[0] && t < 30) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 30) check_eq("enable_timeout", 1'b0, 1'b1);
    endtask

    logic [31:0]  w [4];
    logic [127:0] k_old;
    logic [127:0] k_new;

    initial begin
        idle(3);
        @(negedge clk);
        resetn = 1'b1;

        // Reference vector from the AES test key.
        k_old = 128'h0f0e0d0c0b0a09080706050403020100;
        @(negedge clk);
        kl = 1'b1;
        ck = k_old;
        send_word(32'h33221100, 1'b0, k_old);
        send_word(32'h77665544, 1'b0, k_old);
        send_word(32'hbbaa9988, 1'b0, k_old);
        send_word(32'hffeeddcc, 1'b0, k_old);
        wait_en0();
        check_eq("vec_text", txt_o[0], 128'hf0e0d0c0b0a090807060504030201000);
        check_eq("vec_key",  key_o[0], k_old);

        // Back-to-back blocks: the gap-8 loader holds after the 8th word.
        idle(10);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                w[i] = $urandom;
                send_word(w[i], 1'b0, k_old);
            end
        end
        #1;
        check_eq("b2b_hold_rdy", rdy[0], 1'b0);
        wait_en0();
        check_eq("b2b_text2", txt_o[0], {w[3], w[2], w[1], w[0]} ^ k_old);

        // Gaps between words, then valid held while the loader is in HOLD.
        idle(10);
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            send_word(w[i], 1'b0, k_old);
            if (i == 0) idle(3);
        end
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0, k_old);
        idle(2);
        wait_en0();

        // New key on the issue edge: old key used now, new key for the next block.
        idle(12);
        k_new = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            send_word(w[i], (i == 3), k_new);
        end
        wait_en0();
        check_eq("kl_issue_key",  key_o[0], k_old);
        check_eq("kl_issue_text", txt_o[0], {w[3], w[2], w[1], w[0]} ^ k_old);
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            send_word(w[i], 1'b0, k_new);
        end
        wait_en0();
        check_eq("kl_next_key",  key_o[0], k_new);
        check_eq("kl_next_text", txt_o[0], {w[3], w[2], w[1], w[0]} ^ k_new);

        // Reset mid-fill discards the partial block and the key register.
        idle(12);
        send_word($urandom, 1'b0, k_new);
        send_word($urandom, 1'b0, k_new);
        @(negedge clk);
        resetn = 1'b0;
        vin    = 1'b0;
        #1;
        check_eq("midrst_txt",  txt_o[0], '0);
        check_eq("midrst_busy", busy_o[0], 1'b0);
        idle(2);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            send_word(w[i], 1'b0, '0);
        end
        wait_en0();
        check_eq("postrst_text", txt_o[0], {w[3], w[2], w[1], w[0]});
        check_eq("postrst_key",  key_o[0], '0);

`ifdef AES_LOADER_BLKCNT_EN
        idle(12);
        @(negedge clk);
        force u_dut0.blk_cnt_q = 16'hFFFF;
        e_blk[0] = 16'hFFFF;
        #1;
        release u_dut0.blk_cnt_q;
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0, '0);
        wait_en0();
        check_eq("blk_wrap", blk_o[0], 16'd0);
`endif

        // Random traffic: valid, words and key loads all randomised.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            vin = ($urandom_range(0, 9) < 6);
            win = $urandom;
            kl  = ($urandom_range(0, 9) == 0);
            ck  = {$urandom, $urandom, $urandom, $urandom};
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
